// File: rtl/pooling_2x2.sv
// 2x2 pooling of the top-left tile window (average, or max when POOL_MAX_EN is defined); result 3 edges after start is sampled.
// Level handshake: start is held until finish; dropping start aborts an in-flight result or releases a finished one.
module pooling_2x2 #(
  parameter int N      = 5,
  parameter int DATA_W = 16,
  parameter int OUT_W  = 14
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic signed [DATA_W-1:0] image_in [0:N-1][0:N-1],
  output logic                     finish,
  output logic [OUT_W-1:0]         pixel_out
);

  localparam int SW = DATA_W + 2;

  typedef enum logic [1:0] {IDLE, LOAD, SUM, DONE} state_t;

  state_t                    state_q, state_d;
  logic signed [DATA_W-1:0]  w_q [4];
  logic signed [DATA_W-1:0]  w_d [4];
  logic signed [DATA_W:0]    pa_q, pa_d, pb_q, pb_d;
  logic [OUT_W-1:0]          pixel_q, pixel_d;
  logic                      finish_q, finish_d;
  logic signed [SW-1:0]      full;
`ifndef POOL_MAX_EN
  logic signed [SW-1:0]      sum;
  logic signed [SW-1:0]      bias;
`endif

  always_comb begin
    state_d  = state_q;
    finish_d = finish_q;
    pixel_d  = pixel_q;
    w_d      = w_q;
    pa_d     = pa_q;
    pb_d     = pb_q;
    full     = '0;
`ifndef POOL_MAX_EN
    sum      = '0;
    bias     = '0;
`endif
    case (state_q)
      IDLE: begin
        finish_d = 1'b0;
        if (start) begin
          w_d[0]  = image_in[0][0];
          w_d[1]  = image_in[0][1];
          w_d[2]  = image_in[1][0];
          w_d[3]  = image_in[1][1];
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (!start) begin
          state_d = IDLE;
        end else begin
`ifdef POOL_MAX_EN
          pa_d = (w_q[0] > w_q[1]) ? (DATA_W+1)'(w_q[0]) : (DATA_W+1)'(w_q[1]);
          pb_d = (w_q[2] > w_q[3]) ? (DATA_W+1)'(w_q[2]) : (DATA_W+1)'(w_q[3]);
`else
          pa_d = (DATA_W+1)'(w_q[0]) + (DATA_W+1)'(w_q[1]);
          pb_d = (DATA_W+1)'(w_q[2]) + (DATA_W+1)'(w_q[3]);
`endif
          state_d = SUM;
        end
      end
      SUM: begin
        if (!start) begin
          state_d = IDLE;
        end else begin
`ifdef POOL_MAX_EN
          full = (pa_q > pb_q) ? SW'(pa_q) : SW'(pb_q);
`else
          // Bias negative sums by 3 so the arithmetic shift truncates toward zero.
          sum  = SW'(pa_q) + SW'(pb_q);
          bias = sum[SW-1] ? SW'(3) : '0;
          full = (sum + bias) >>> 2;
`endif
          pixel_d  = full[OUT_W-1:0];
          finish_d = 1'b1;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (!start) begin
          finish_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      finish_q <= 1'b0;
      pixel_q  <= '0;
      pa_q     <= '0;
      pb_q     <= '0;
      for (int i = 0; i < 4; i++) w_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      finish_q <= finish_d;
      pixel_q  <= pixel_d;
      pa_q     <= pa_d;
      pb_q     <= pb_d;
      for (int i = 0; i < 4; i++) w_q[i] <= w_d[i];
    end
  end

  assign finish    = finish_q;
  assign pixel_out = pixel_q;

endmodule

// File: tb/tb_pooling_2x2.sv
// Directed and randomized bench for pooling_2x2 against an arithmetic reference model.
module tb_pooling_2x2;

  localparam int N      = 5;
  localparam int DATA_W = 16;
  localparam int OUT_W  = 14;

  logic                     clk;
  logic                     rst_n;
  logic                     start;
  logic signed [DATA_W-1:0] img [0:N-1][0:N-1];
  logic                     finish;
  logic [OUT_W-1:0]         pixel_out;

  int total;
  int bad;

  pooling_2x2 #(.N(N), .DATA_W(DATA_W), .OUT_W(OUT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .image_in  (img),
    .finish    (finish),
    .pixel_out (pixel_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [OUT_W-1:0] model(input int a, input int b, input int c, input int d);
    int r;
`ifdef POOL_MAX_EN
    r = a;
    if (b > r) r = b;
    if (c > r) r = c;
    if (d > r) r = d;
`else
    r = (a + b + c + d) / 4;
`endif
    return OUT_W'(r);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic scramble();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        img[i][j] = DATA_W'($urandom);
  endtask

  task automatic do_req(input int a, input int b, input int c, input int d, input string tag);
    logic [OUT_W-1:0] e;
    e = model(a, b, c, d);
    scramble();
    img[0][0] = DATA_W'(a);
    img[0][1] = DATA_W'(b);
    img[1][0] = DATA_W'(c);
    img[1][1] = DATA_W'(d);
    start = 1'b1;
    @(posedge clk); #1;
    scramble();
    @(posedge clk); #1;
    check({tag, " early_finish"}, 32'(finish), 32'd0);
    @(posedge clk); #1;
    check({tag, " finish"}, 32'(finish), 32'd1);
    check({tag, " pixel"}, 32'(pixel_out), 32'(e));
    @(posedge clk); #1;
    check({tag, " hold_finish"}, 32'(finish), 32'd1);
    check({tag, " hold_pixel"}, 32'(pixel_out), 32'(e));
    start = 1'b0;
    @(posedge clk); #1;
    check({tag, " drop_finish"}, 32'(finish), 32'd0);
    check({tag, " keep_pixel"}, 32'(pixel_out), 32'(e));
  endtask

  initial begin
    logic [OUT_W-1:0] prev;
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    start = 1'b0;
    scramble();
    #12;
    check("reset finish", 32'(finish), 32'd0);
    check("reset pixel", 32'(pixel_out), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle finish", 32'(finish), 32'd0);

`ifdef POOL_MAX_EN
    do_req(10, 20, 30, 41, "basic");
    check("basic const", 32'(pixel_out), 32'd41);
    do_req(5, 97, 12, 40, "max");
    check("max const", 32'(pixel_out), 32'd97);
`else
    do_req(10, 20, 30, 41, "basic");
    check("basic const", 32'(pixel_out), 32'd25);
    do_req(5, 97, 12, 40, "avg2");
    check("avg2 const", 32'(pixel_out), 32'd38);
`endif
    do_req(1, 1, 1, 0, "trunc_small");
    do_req(99, 99, 99, 99, "trunc_99");
    check("trunc_99 const", 32'(pixel_out), 32'd99);
    do_req(-1, -1, -1, 0, "neg_small");
    do_req(-5, -6, -7, -8, "neg");
    do_req(32767, 32767, 32767, 32767, "pos_full");
    do_req(-32768, -32768, -32768, -32768, "neg_full");

    // Abort after one edge of start: nothing completes and the last result stays put.
    do_req(40, 50, 60, 70, "pre_abort");
    prev = pixel_out;
    scramble();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      check("abort1 finish", 32'(finish), 32'd0);
      check("abort1 pixel", 32'(pixel_out), 32'(prev));
    end
    // Abort from the SUM stage.
    start = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("abort2 finish", 32'(finish), 32'd0);
      check("abort2 pixel", 32'(pixel_out), 32'(prev));
    end
    do_req(3, 7, 11, 13, "post_abort");

    // Asynchronous reset while holding a finished result.
    scramble();
    img[0][0] = 16'sd80; img[0][1] = 16'sd80; img[1][0] = 16'sd80; img[1][1] = 16'sd80;
    start = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("pre_reset finish", 32'(finish), 32'd1);
    check("pre_reset pixel", 32'(pixel_out), 32'd80);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset finish", 32'(finish), 32'd0);
    check("async_reset pixel", 32'(pixel_out), 32'd0);
    start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_reset finish", 32'(finish), 32'd0);
    do_req(8, 16, 24, 32, "after_reset");

    for (int it = 0; it < 300; it++) begin
      do_req($urandom_range(0, 99), $urandom_range(0, 99),
             $urandom_range(0, 99), $urandom_range(0, 99), "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pooling_2x2.md
Name: pooling_2x2

Overview:
- Clocked 2x2 pooling unit for the CNN datapath.
- On a start request it takes the top-left 2x2 window of an NxN pixel tile and produces one pooled pixel: the average by default, or the maximum when the optional feature is compiled in.
- It raises finish when the pixel is valid.
- It sits between a convolution output buffer and the next layer's input buffer.

Parameters:
- N, 5, tile dimension (rows = cols); the window is always rows 0..1, cols 0..1; N >= 2.
- DATA_W, 16, width of each signed input pixel.
- OUT_W, 14, width of pixel_out.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  level request; must stay high until finish is seen.
- image_in  input  N x N x DATA_W (unpacked [0:N-1][0:N-1], signed)  pixel tile; only [0][0], [0][1], [1][0], [1][1] are used.
- finish  output  1  result valid; held while start stays high.
- pixel_out  output  OUT_W  pooled pixel.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, finish=0, pixel_out=0, internal window/sum registers=0. Reset overrides everything, including mid-operation.
- FSM states: IDLE, LOAD, SUM, DONE.
- IDLE:
  - start=1 at a rising edge: capture the four window pixels into registers, go to LOAD.
  - Otherwise stay in IDLE, finish=0.
- LOAD: compute the pair sums (p00+p01) and (p10+p11), each DATA_W+1 bits signed; go to SUM.
- SUM:
  - Final sum is DATA_W+2 bits signed.
  - Result = sum/4, truncated toward zero (identical to a right shift by 2 for non-negative data).
  - pixel_out <= low OUT_W bits of the result. finish <= 1. Go to DONE.
- DONE:
  - Hold finish=1 and pixel_out while start=1.
  - start=0: finish <= 0 on the next edge, go to IDLE. pixel_out keeps its last value.
- Latency: finish and pixel_out are valid 3 rising edges after the edge that samples start=1.
- start falls in LOAD or SUM: abort to IDLE on the next edge; finish stays 0; pixel_out is unchanged.
- Changes to image_in after capture do not affect the in-flight result.
- A new request needs start low for at least one edge (the DONE→IDLE transition) and then high again.
- Non-negative 8-bit-range pixels (0..255) always fit exactly in pixel_out; the upper result bits are simply truncated.

Optional Feature:
- POOL_MAX_EN defined:
  - SUM stage outputs max(p00, p01, p10, p11), signed compare, truncated to OUT_W.
  - LOAD computes the pair maxima instead of the pair sums.
  - Timing and handshake are unchanged.
- Not defined: average pooling as described above.

Test Plan:
- Reset: assert rst_n=0 mid-DONE with finish=1 -> finish=0 and pixel_out=0 immediately (asynchronously); state IDLE after release.
- Basic average: window 10, 20, 30, 41 (others random), start=1 -> finish=1 after 3 edges, pixel_out=25. Drop start -> finish=0 the next edge.
- Randomized: 300 iterations, window values 0..99 -> pixel_out == (sum of 4)/4 zero-extended, finish=1. After start low for one period -> finish=0.
- Truncation: window 1, 1, 1, 0 -> pixel_out=0. Window 99, 99, 99, 99 -> pixel_out=99.
- Abort: start high for 1 edge then low -> finish never asserts, pixel_out keeps its previous value.
- POOL_MAX_EN build: window 5, 97, 12, 40 -> pixel_out=97 with the same 3-edge latency.
